// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, quarter indices, RW constants and line-drive decode shared by the I2C controller and peripheral
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} state_t;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  // returns {scl_oe, sda_oe} for a given slot position; b is the SDA bit level of a bit slot
  function automatic logic [1:0] line_drive(state_t s, logic [1:0] q, logic b);
    return s == IDLE ? 2'b00 :
           s == START ? {q == Q3, q >= Q2} :
           s == STOP ? {q == Q0, q <= Q1} :
           {q == Q0 || q == Q3, ~b};
  endfunction
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: CLK_DIV divider producing a registered quarter-period tick, frozen while hold is high
module i2c_quarter_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  output logic tick
);
  logic [7:0] cnt;
  logic wrap;
  assign wrap = cnt == 8'(CLK_DIV - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= 8'd0;
      tick <= 1'b0;
    end else if (hold) begin
      tick <= 1'b0;
    end else begin
      cnt <= wrap ? 8'd0 : cnt + 8'd1;
      tick <= wrap;
    end
  end
endmodule

// File: rtl/i2c_controller.sv
// i2c_controller: single-byte I2C master (write or read) with open-drain line control and clock stretching
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);
  state_t state, ns;
  logic [1:0] q, nq;
  logic [2:0] bit_cnt, nb;
  logic rw_r, smp, tick, last, nbit;
  logic [6:0] addr_r;
  logic [7:0] wdata_r, tmp, abyte;
  assign last = state == STOP && q == Q3 && tick;
  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (busy & ~last),
    .hold (q == Q1 && !scl_in),
    .tick (tick)
  );
  // next slot position is computed ahead so the line outputs register in step with it
  always_comb begin
    abyte = {addr_r, rw_r};
    ns = state;
    nq = q;
    nb = bit_cnt;
    if (state == IDLE) begin
      if (start) ns = START;
    end else if (tick) begin
      nq = q + 2'd1;
      if (q == Q3) begin
        case (state)
          START: ns = ADDR;
          ADDR: begin
            nb = bit_cnt + 3'd1;
            ns = bit_cnt == 3'd7 ? ADDR_ACK : ADDR;
          end
          ADDR_ACK: ns = smp ? STOP : DATA;
          DATA: begin
            nb = bit_cnt + 3'd1;
            ns = bit_cnt == 3'd7 ? DATA_ACK : DATA;
          end
          DATA_ACK: ns = STOP;
          default: ns = IDLE;
        endcase
      end
    end
    nbit = ns == ADDR ? abyte[3'd7 - nb] :
           (ns == DATA && rw_r == RW_WRITE) ? wdata_r[3'd7 - nb] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      q <= Q0;
      bit_cnt <= 3'd0;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      ack_err <= 1'b0;
      rdata <= 8'h00;
      rw_r <= RW_WRITE;
      addr_r <= 7'h00;
      wdata_r <= 8'h00;
      tmp <= 8'h00;
      smp <= 1'b1;
    end else begin
      state <= ns;
      q <= nq;
      bit_cnt <= nb;
      {scl_oe, sda_oe} <= line_drive(ns, nq, nbit);
      busy <= ns != IDLE;
      done <= state == STOP && ns == IDLE;
      if (state == IDLE && start) begin
        rw_r <= rw;
        addr_r <= addr;
        wdata_r <= wdata;
        ack_err <= 1'b0;
      end
      if (tick && q == Q2) begin
        smp <= sda_in;
        if (state == DATA && rw_r == RW_READ) tmp <= {tmp[6:0], sda_in};
      end
      if (tick && q == Q3 && state == ADDR_ACK && smp) ack_err <= 1'b1;
      if (tick && q == Q3 && state == DATA_ACK) begin
        if (rw_r == RW_READ) rdata <= tmp;
        else if (smp) ack_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: directed bench with an I2C target model on the open-drain lines
module tb_i2c_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic busy, done, ack_err, scl_oe, sda_oe;
  logic [7:0] rdata;
  logic scl_in, sda_in, scl_bus, tgt_pull;
  logic ack_en = 1'b1;
  logic rw_t = 1'b0;
  logic str_req = 1'b0;
  logic [7:0] tbyte = 8'h00;
  int f = 0, starts = 0, stops = 0, str_left = 0;
  logic [7:0] cap_a = 8'h00, cap_d = 8'h00;
  logic ack1 = 1'b1, ack2 = 1'b1, prev_scl = 1'b1, prev_sda = 1'b1, str_done = 1'b0;
  int errors = 0, checks = 0, cyc = 0, bc = 0;
  always #5 clk = ~clk;
  i2c_controller #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );
  assign scl_bus = ~scl_oe;
  assign scl_in = scl_bus & (str_left == 0);
  assign sda_in = ~sda_oe & ~tgt_pull;
  // f counts SCL falls since accept; slot f-1 is the bit slot currently on the bus
  always_comb begin
    tgt_pull = 1'b0;
    if (f == 9 && ack_en) tgt_pull = 1'b1;
    if (f == 18 && ack_en && !rw_t) tgt_pull = 1'b1;
    if (rw_t && f >= 10 && f <= 17) tgt_pull = !tbyte[17 - f];
  end
  always @(posedge clk) begin
    prev_scl <= scl_bus;
    prev_sda <= sda_in;
    if (start && !busy) begin
      f <= 0; starts <= 0; stops <= 0; cap_a <= 8'h00; cap_d <= 8'h00;
      ack1 <= 1'b1; ack2 <= 1'b1; str_done <= 1'b0; str_left <= 0;
    end else begin
      if (prev_scl && !scl_bus) f <= f + 1;
      if (!prev_scl && scl_bus) begin
        if (f >= 1 && f <= 8) cap_a <= {cap_a[6:0], sda_in};
        else if (f == 9) ack1 <= sda_in;
        else if (f >= 10 && f <= 17) cap_d <= {cap_d[6:0], sda_in};
        else if (f == 18) ack2 <= sda_in;
      end
      if (prev_scl && scl_bus && prev_sda && !sda_in) starts <= starts + 1;
      if (prev_scl && scl_bus && !prev_sda && sda_in) stops <= stops + 1;
      if (str_req && f == 4 && scl_bus && !str_done) begin
        str_left <= 10;
        str_done <= 1'b1;
      end else if (str_left > 0) str_left <= str_left - 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic r, input logic [6:0] a, input logic [7:0] d,
                     input logic ack, input logic strq, output int n);
    @(negedge clk);
    rw = r; addr = a; wdata = d; ack_en = ack; rw_t = r; str_req = strq; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rw = ~r; addr = ~a; wdata = ~d;
    chk("busy_after_accept", {31'd0, busy}, 1);
    chk("ack_err_cleared", {31'd0, ack_err}, 0);
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_low_at_done", {31'd0, busy}, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ack_err", {31'd0, ack_err}, 0);
    chk("rst_rdata", {24'd0, rdata}, 8'h00);
    chk("rst_lines", {30'd0, scl_oe, sda_oe}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    tbyte = 8'h3C;
    run(1'b0, 7'h2A, 8'hA5, 1'b1, 1'b0, cyc);
    chk("wr_done_cycle", cyc, 321);
    chk("wr_addr_byte", {24'd0, cap_a}, 8'h54);
    chk("wr_data_byte", {24'd0, cap_d}, 8'hA5);
    chk("wr_acks", {30'd0, ack1, ack2}, 0);
    chk("wr_ack_err", {31'd0, ack_err}, 0);
    chk("wr_start_stop", {starts[15:0], stops[15:0]}, 32'h0001_0001);
    chk("wr_scl_falls", f, 19);
    chk("wr_lines_idle", {30'd0, scl_oe, sda_oe}, 0);
    run(1'b1, 7'h2A, 8'h00, 1'b1, 1'b0, cyc);
    chk("rd_done_cycle", cyc, 321);
    chk("rd_addr_byte", {24'd0, cap_a}, 8'h55);
    chk("rd_bus_byte", {24'd0, cap_d}, 8'h3C);
    chk("rd_addr_ack", {31'd0, ack1}, 0);
    chk("rd_master_nack", {31'd0, ack2}, 1);
    chk("rd_rdata", {24'd0, rdata}, 8'h3C);
    chk("rd_ack_err", {31'd0, ack_err}, 0);
    run(1'b0, 7'h2A, 8'hA5, 1'b0, 1'b0, cyc);
    chk("nack_done_cycle", cyc, 177);
    chk("nack_ack_err", {31'd0, ack_err}, 1);
    chk("nack_scl_falls", f, 10);
    chk("nack_stop", stops, 1);
    chk("nack_rdata_held", {24'd0, rdata}, 8'h3C);
    repeat (5) @(posedge clk);
    #1;
    chk("nack_ack_err_held", {31'd0, ack_err}, 1);
    run(1'b0, 7'h13, 8'h0F, 1'b1, 1'b1, cyc);
    chk("str_done_cycle", cyc, 331);
    chk("str_addr_byte", {24'd0, cap_a}, 8'h26);
    chk("str_data_byte", {24'd0, cap_d}, 8'h0F);
    chk("str_ack_err", {31'd0, ack_err}, 0);
    str_req = 1'b0;
    @(negedge clk);
    rw = 1'b0; addr = 7'h2A; wdata = 8'hA5; rw_t = 1'b0; ack_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    @(negedge clk);
    start = 1'b1; rw = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mid_start_busy", {31'd0, busy}, 1);
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    ack_en = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_lines", {30'd0, scl_oe, sda_oe}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_done", {31'd0, done}, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (busy || done || scl_oe || sda_oe) bc++;
    end
    chk("no_queued_txn", bc, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
